// File: rtl/vx_fetch_pkg.sv
// Shared sizes and record types for the fetch stage.
// The FETCH_PERF_EN build option uses PERF_CTR_BITS for its counters.
package vx_fetch_pkg;

  localparam int NUM_WARPS     = 4;
  localparam int NUM_THREADS   = 4;
  localparam int XLEN          = 32;
  localparam int UUID_WIDTH    = 44;
  localparam int PERF_CTR_BITS = 44;
  localparam int NW_WIDTH      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  typedef struct packed {
    logic [NUM_THREADS-1:0] tmask;
    logic [XLEN-1:0]        pc;
    logic [UUID_WIDTH-1:0]  uuid;
  } warp_ctx_t;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]  uuid;
    logic [NW_WIDTH-1:0]    wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [XLEN-1:0]        pc;
    logic [31:0]            instr;
  } fetch_data_t;

  function automatic fetch_data_t make_fetch_data(input logic [NW_WIDTH-1:0] wid,
                                                  input warp_ctx_t           ctx,
                                                  input logic [31:0]         instr);
    fetch_data_t fd;
    fd.uuid  = ctx.uuid;
    fd.wid   = wid;
    fd.tmask = ctx.tmask;
    fd.pc    = ctx.pc;
    fd.instr = instr;
    return fd;
  endfunction

endpackage

// File: rtl/vx_elastic_buffer.sv
// Registered elastic FIFO. ready_in depends only on the current occupancy, never on ready_out.
// SIZE must be a power of two so that the pointers wrap naturally.
module VX_elastic_buffer #(
  parameter int DATAW = 32,
  parameter int SIZE  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [DATAW-1:0] data_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [DATAW-1:0] data_out
);

  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CW = AW + 1;

  logic [DATAW-1:0] mem_q [SIZE];
  logic [DATAW-1:0] mem_d [SIZE];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push, pop;

  assign ready_in  = (cnt_q != CW'(SIZE));
  assign valid_out = (cnt_q != '0);
  assign data_out  = mem_q[rd_ptr_q];
  assign push      = valid_in & ready_in;
  assign pop       = valid_out & ready_out;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/vx_fetch_tag_table.sv
// Per-warp context store for in-flight I-cache reads.
// It also keeps the pending-warp mask and the outstanding-read count.
module vx_fetch_tag_table
  import vx_fetch_pkg::*;
#(
  parameter int MAX_PENDING = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_en,
  input  logic [NW_WIDTH-1:0]                wr_wid,
  input  warp_ctx_t                          wr_ctx,
  input  logic                               clr_en,
  input  logic [NW_WIDTH-1:0]                rd_wid,
  output warp_ctx_t                          rd_ctx,
  output logic [NUM_WARPS-1:0]               pending_mask,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending_cnt
);

  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  warp_ctx_t            table_q [NUM_WARPS];
  warp_ctx_t            table_d [NUM_WARPS];
  logic [NUM_WARPS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // A warp is never written and cleared in the same cycle, because the mask gates both.
  always_comb begin
    table_d = table_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    if (wr_en) begin
      table_d[wr_wid] = wr_ctx;
      mask_d[wr_wid]  = 1'b1;
    end
    if (clr_en) begin
      mask_d[rd_wid] = 1'b0;
    end
    case ({wr_en, clr_en})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
      cnt_q  <= '0;
    end else begin
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    table_q <= table_d;
  end

  assign rd_ctx       = table_q[rd_wid];
  assign pending_mask = mask_q;
  assign pending_cnt  = cnt_q;

  cnt_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(wr_en && !clr_en && cnt_q == CNT_W'(MAX_PENDING)))
    else $error("vx_fetch_tag_table: pending_cnt overflow");

  cnt_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(clr_en && !wr_en && cnt_q == '0))
    else $error("vx_fetch_tag_table: pending_cnt underflow");

  cnt_matches_mask: assert property (@(posedge clk) disable iff (reset)
    cnt_q == CNT_W'($countones(mask_q)))
    else $error("vx_fetch_tag_table: pending_cnt out of step with pending_mask");

endmodule

// File: rtl/vx_fetch.sv
// Fetch stage: issues word-aligned I-cache reads per scheduled warp and parks the warp context until the response.
// Optional FETCH_PERF_EN adds I-cache stall and latency counters.
module vx_fetch
  import vx_fetch_pkg::*;
#(
  parameter int MAX_PENDING = 4
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     sched_valid,
  output logic                     sched_ready,
  input  logic [NW_WIDTH-1:0]      sched_wid,
  input  logic [NUM_THREADS-1:0]   sched_tmask,
  input  logic [XLEN-1:0]          sched_pc,
  input  logic [UUID_WIDTH-1:0]    sched_uuid,

  output logic                     icache_req_valid,
  input  logic                     icache_req_ready,
  output logic [XLEN-3:0]          icache_req_addr,
  output logic [NW_WIDTH-1:0]      icache_req_tag,

  input  logic                     icache_rsp_valid,
  output logic                     icache_rsp_ready,
  input  logic [31:0]              icache_rsp_data,
  input  logic [NW_WIDTH-1:0]      icache_rsp_tag,

  output logic                     fetch_valid,
  input  logic                     fetch_ready,
  output logic [NW_WIDTH-1:0]      fetch_wid,
  output logic [NUM_THREADS-1:0]   fetch_tmask,
  output logic [XLEN-1:0]          fetch_pc,
  output logic [31:0]              fetch_instr,
  output logic [UUID_WIDTH-1:0]    fetch_uuid,

  output logic                     busy
`ifdef FETCH_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0] perf_icache_stalls,
  output logic [PERF_CTR_BITS-1:0] perf_icache_lat
`endif
);

  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  logic [NUM_WARPS-1:0] pending_mask;
  logic [CNT_W-1:0]     pending_cnt;
  warp_ctx_t            req_ctx, rsp_ctx;
  logic                 can_req, req_fire, rsp_fire, rsp_hit;
  logic                 buf_ready_in, buf_valid_out;
  fetch_data_t          buf_din, buf_dout;

  assign can_req          = ~pending_mask[sched_wid] & (pending_cnt < CNT_W'(MAX_PENDING));
  assign icache_req_valid = sched_valid & can_req;
  assign sched_ready      = icache_req_ready & can_req;
  assign icache_req_addr  = sched_pc[XLEN-1:2];
  assign icache_req_tag   = sched_wid;
  assign req_fire         = sched_valid & sched_ready;

  assign req_ctx.tmask = sched_tmask;
  assign req_ctx.pc    = sched_pc;
  assign req_ctx.uuid  = sched_uuid;

  // Responses for warps that are not pending (e.g. issued before a reset) are accepted and dropped.
  assign icache_rsp_ready = buf_ready_in;
  assign rsp_fire         = icache_rsp_valid & buf_ready_in;
  assign rsp_hit          = rsp_fire & pending_mask[icache_rsp_tag];

  vx_fetch_tag_table #(
    .MAX_PENDING (MAX_PENDING)
  ) tag_table (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (req_fire),
    .wr_wid       (sched_wid),
    .wr_ctx       (req_ctx),
    .clr_en       (rsp_hit),
    .rd_wid       (icache_rsp_tag),
    .rd_ctx       (rsp_ctx),
    .pending_mask (pending_mask),
    .pending_cnt  (pending_cnt)
  );

  assign buf_din = make_fetch_data(icache_rsp_tag, rsp_ctx, icache_rsp_data);

  VX_elastic_buffer #(
    .DATAW ($bits(fetch_data_t)),
    .SIZE  (2)
  ) out_buf (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (rsp_hit),
    .ready_in  (buf_ready_in),
    .data_in   (buf_din),
    .valid_out (buf_valid_out),
    .ready_out (fetch_ready),
    .data_out  (buf_dout)
  );

  assign fetch_valid = buf_valid_out;
  assign fetch_wid   = buf_dout.wid;
  assign fetch_tmask = buf_dout.tmask;
  assign fetch_pc    = buf_dout.pc;
  assign fetch_instr = buf_dout.instr;
  assign fetch_uuid  = buf_dout.uuid;
  assign busy        = (pending_cnt != '0) | buf_valid_out;

`ifdef FETCH_PERF_EN
  logic [PERF_CTR_BITS-1:0] stalls_q, stalls_d, lat_q, lat_d;

  always_comb begin
    stalls_d = stalls_q + PERF_CTR_BITS'(icache_req_valid & ~icache_req_ready);
    lat_d    = lat_q + PERF_CTR_BITS'(pending_cnt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stalls_q <= '0;
      lat_q    <= '0;
    end else begin
      stalls_q <= stalls_d;
      lat_q    <= lat_d;
    end
  end

  assign perf_icache_stalls = stalls_q;
  assign perf_icache_lat    = lat_q;
`endif

  stale_rsp_dropped: assert property (@(posedge clk) disable iff (reset)
    !(rsp_fire && !pending_mask[icache_rsp_tag]))
    else $warning("vx_fetch: response for idle wid %0d dropped", icache_rsp_tag);

endmodule

// File: tb/tb_vx_fetch.sv
// Testbench for vx_fetch: directed scenarios plus a random phase, all checked against a
// queue/array reference model of the fetch rules. Perf ports are connected only under FETCH_PERF_EN.
module tb_vx_fetch;
  import vx_fetch_pkg::*;

  localparam int MAXP = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   sched_valid, sched_ready;
  logic [NW_WIDTH-1:0]    sched_wid;
  logic [NUM_THREADS-1:0] sched_tmask;
  logic [XLEN-1:0]        sched_pc;
  logic [UUID_WIDTH-1:0]  sched_uuid;
  logic                   icache_req_valid, icache_req_ready;
  logic [XLEN-3:0]        icache_req_addr;
  logic [NW_WIDTH-1:0]    icache_req_tag;
  logic                   icache_rsp_valid, icache_rsp_ready;
  logic [31:0]            icache_rsp_data;
  logic [NW_WIDTH-1:0]    icache_rsp_tag;
  logic                   fetch_valid, fetch_ready;
  logic [NW_WIDTH-1:0]    fetch_wid;
  logic [NUM_THREADS-1:0] fetch_tmask;
  logic [XLEN-1:0]        fetch_pc;
  logic [31:0]            fetch_instr;
  logic [UUID_WIDTH-1:0]  fetch_uuid;
  logic                   busy;
`ifdef FETCH_PERF_EN
  logic [PERF_CTR_BITS-1:0] perfStalls, perfLat;
`endif

  always #5 clk = ~clk;

  vx_fetch #(.MAX_PENDING(MAXP)) dut (
    .clk              (clk),
    .reset            (reset),
    .sched_valid      (sched_valid),
    .sched_ready      (sched_ready),
    .sched_wid        (sched_wid),
    .sched_tmask      (sched_tmask),
    .sched_pc         (sched_pc),
    .sched_uuid       (sched_uuid),
    .icache_req_valid (icache_req_valid),
    .icache_req_ready (icache_req_ready),
    .icache_req_addr  (icache_req_addr),
    .icache_req_tag   (icache_req_tag),
    .icache_rsp_valid (icache_rsp_valid),
    .icache_rsp_ready (icache_rsp_ready),
    .icache_rsp_data  (icache_rsp_data),
    .icache_rsp_tag   (icache_rsp_tag),
    .fetch_valid      (fetch_valid),
    .fetch_ready      (fetch_ready),
    .fetch_wid        (fetch_wid),
    .fetch_tmask      (fetch_tmask),
    .fetch_pc         (fetch_pc),
    .fetch_instr      (fetch_instr),
    .fetch_uuid       (fetch_uuid),
    .busy             (busy)
`ifdef FETCH_PERF_EN
    ,
    .perf_icache_stalls (perfStalls),
    .perf_icache_lat    (perfLat)
`endif
  );

  int numChecks = 0;
  int numErrors = 0;
  int delivered = 0;

  // Reference model: which warps wait on the I-cache, their parked context, and the decode-side queue (capacity 2).
  logic                   modelPending [NUM_WARPS];
  logic [NUM_THREADS-1:0] modelTmask   [NUM_WARPS];
  logic [XLEN-1:0]        modelPc      [NUM_WARPS];
  logic [UUID_WIDTH-1:0]  modelUuid    [NUM_WARPS];
  fetch_data_t            modelOut     [$];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at t=%0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int pendCount();
    int n = 0;
    for (int w = 0; w < NUM_WARPS; w++) if (modelPending[w]) n++;
    return n;
  endfunction

  task automatic modelReset();
    for (int w = 0; w < NUM_WARPS; w++) modelPending[w] = 1'b0;
    modelOut.delete();
  endtask

  task automatic applyStimulus(input logic sv, input int wid, input logic [NUM_THREADS-1:0] tm,
                               input logic [XLEN-1:0] pc, input logic [UUID_WIDTH-1:0] uuid,
                               input logic reqRdy, input logic rv, input int rtag,
                               input logic [31:0] rdata, input logic frdy);
    sched_valid      = sv;
    sched_wid        = NW_WIDTH'(wid);
    sched_tmask      = tm;
    sched_pc         = pc;
    sched_uuid       = uuid;
    icache_req_ready = reqRdy;
    icache_rsp_valid = rv;
    icache_rsp_tag   = NW_WIDTH'(rtag);
    icache_rsp_data  = rdata;
    fetch_ready      = frdy;
  endtask

  // Mid-cycle comparison of every DUT output against the model state at the start of the cycle.
  task automatic checkModel();
    int  cnt;
    logic canReq;
    cnt    = pendCount();
    canReq = !modelPending[sched_wid] && (cnt < MAXP);
    checkOutput("req_valid", icache_req_valid, sched_valid && canReq);
    checkOutput("sched_ready", sched_ready, icache_req_ready && canReq);
    if (sched_valid && canReq) begin
      checkOutput("req_addr", icache_req_addr, sched_pc >> 2);
      checkOutput("req_tag", icache_req_tag, sched_wid);
    end
    checkOutput("rsp_ready", icache_rsp_ready, modelOut.size() < 2);
    checkOutput("fetch_valid", fetch_valid, modelOut.size() != 0);
    checkOutput("busy", busy, (cnt != 0) || (modelOut.size() != 0));
    if (modelOut.size() != 0) begin
      checkOutput("fetch_wid", fetch_wid, modelOut[0].wid);
      checkOutput("fetch_tmask", fetch_tmask, modelOut[0].tmask);
      checkOutput("fetch_pc", fetch_pc, modelOut[0].pc);
      checkOutput("fetch_instr", fetch_instr, modelOut[0].instr);
      checkOutput("fetch_uuid", fetch_uuid, modelOut[0].uuid);
    end
    if (fetch_valid && fetch_ready) delivered++;
  endtask

  task automatic updateModel();
    logic pop, acc, fire;
    fetch_data_t fd;
    if (reset) return;
    pop  = (modelOut.size() != 0) && fetch_ready;
    acc  = icache_rsp_valid && (modelOut.size() < 2);
    fire = sched_valid && icache_req_ready && !modelPending[sched_wid] && (pendCount() < MAXP);
    if (pop) void'(modelOut.pop_front());
    if (acc && modelPending[icache_rsp_tag]) begin
      fd.wid   = icache_rsp_tag;
      fd.tmask = modelTmask[icache_rsp_tag];
      fd.pc    = modelPc[icache_rsp_tag];
      fd.uuid  = modelUuid[icache_rsp_tag];
      fd.instr = icache_rsp_data;
      modelOut.push_back(fd);
      modelPending[icache_rsp_tag] = 1'b0;
    end
    if (fire) begin
      modelPending[sched_wid] = 1'b1;
      modelTmask[sched_wid]   = sched_tmask;
      modelPc[sched_wid]      = sched_pc;
      modelUuid[sched_wid]    = sched_uuid;
    end
  endtask

  task automatic midCycle();
    @(negedge clk);
    checkModel();
  endtask

  task automatic endCycle();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic runCycle();
    midCycle();
    endCycle();
  endtask

  task automatic sendReq(input int wid, input logic [XLEN-1:0] pc, input logic frdy);
    applyStimulus(1'b1, wid, NUM_THREADS'(wid + 5), pc, UUID_WIDTH'(pc) + 44'h1000, 1'b1, 1'b0, 0, 32'h0, frdy);
    runCycle();
  endtask

  task automatic sendRsp(input int tag, input logic [31:0] data, input logic frdy);
    applyStimulus(1'b0, 0, '0, '0, '0, 1'b1, 1'b1, tag, data, frdy);
    runCycle();
  endtask

  task automatic idleCycle(input logic frdy);
    applyStimulus(1'b0, 0, '0, '0, '0, 1'b1, 1'b0, 0, 32'h0, frdy);
    runCycle();
  endtask

  // Answer every pending warp and let decode drain, within a fixed cycle budget.
  task automatic drainAll();
    int tag;
    for (int c = 0; c < 40; c++) begin
      if (pendCount() == 0 && modelOut.size() == 0) break;
      tag = -1;
      for (int w = NUM_WARPS - 1; w >= 0; w--) if (modelPending[w]) tag = w;
      if (tag >= 0) sendRsp(tag, $urandom, 1'b1);
      else idleCycle(1'b1);
    end
    applyStimulus(1'b0, 0, '0, '0, '0, 1'b1, 1'b0, 0, 32'h0, 1'b1);
    midCycle();
    checkOutput("drain_busy", busy, 1'b0);
    endCycle();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pend [$];
    reset = 1'b1;
    modelReset();
    applyStimulus(1'b0, 0, '0, '0, '0, 1'b1, 1'b0, 0, 32'h0, 1'b1);
    runCycle();
    midCycle();
    checkOutput("reset_fetch_valid", fetch_valid, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    endCycle();
    reset = 1'b0;

    $display("[TB] single fetch");
    applyStimulus(1'b1, 1, 4'b1011, 32'h80000004, 44'h5, 1'b1, 1'b0, 0, 32'h0, 1'b1);
    midCycle();
    checkOutput("t1_req_addr", icache_req_addr, 30'h20000001);
    endCycle();
    applyStimulus(1'b0, 0, '0, '0, '0, 1'b1, 1'b1, 1, 32'h00500093, 1'b1);
    midCycle();
    checkOutput("t1_rsp_ready", icache_rsp_ready, 1'b1);
    endCycle();
    idleCycle(1'b1);
    applyStimulus(1'b0, 0, '0, '0, '0, 1'b1, 1'b0, 0, 32'h0, 1'b1);
    midCycle();
    checkOutput("t1_idle_valid", fetch_valid, 1'b0);
    endCycle();

    $display("[TB] out-of-order responses");
    sendReq(0, 32'h00000100, 1'b1);
    sendReq(2, 32'h00000200, 1'b1);
    sendRsp(2, 32'h000000aa, 1'b1);
    applyStimulus(1'b0, 0, '0, '0, '0, 1'b1, 1'b1, 0, 32'h000000bb, 1'b1);
    midCycle();
    checkOutput("t2_first_wid", fetch_wid, 2);
    checkOutput("t2_first_pc", fetch_pc, 32'h200);
    endCycle();
    applyStimulus(1'b0, 0, '0, '0, '0, 1'b1, 1'b0, 0, 32'h0, 1'b1);
    midCycle();
    checkOutput("t2_second_wid", fetch_wid, 0);
    checkOutput("t2_second_instr", fetch_instr, 32'hbb);
    endCycle();

    $display("[TB] pending limit");
    sendReq(0, 32'h10, 1'b1);
    sendReq(1, 32'h14, 1'b1);
    sendReq(2, 32'h18, 1'b1);
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b1, 3, 4'hf, 32'h1c, 44'h77, 1'b1, 1'b0, 0, 32'h0, 1'b1);
      midCycle();
      checkOutput("t3_full_ready", sched_ready, 1'b0);
      checkOutput("t3_full_req", icache_req_valid, 1'b0);
      endCycle();
    end
    applyStimulus(1'b1, 3, 4'hf, 32'h1c, 44'h77, 1'b1, 1'b1, 1, 32'h11, 1'b1);
    midCycle();
    checkOutput("t3_rsp_cycle_ready", sched_ready, 1'b0);
    endCycle();
    applyStimulus(1'b1, 3, 4'hf, 32'h1c, 44'h77, 1'b1, 1'b0, 0, 32'h0, 1'b1);
    midCycle();
    checkOutput("t3_after_rsp_ready", sched_ready, 1'b1);
    endCycle();
    drainAll();

    $display("[TB] same-warp block");
    sendReq(1, 32'h40, 1'b1);
    applyStimulus(1'b1, 1, 4'h3, 32'h44, 44'h9, 1'b1, 1'b0, 0, 32'h0, 1'b1);
    midCycle();
    checkOutput("t4_blocked_req", icache_req_valid, 1'b0);
    endCycle();
    applyStimulus(1'b1, 1, 4'h3, 32'h44, 44'h9, 1'b1, 1'b1, 1, 32'h22, 1'b1);
    midCycle();
    checkOutput("t4_rsp_cycle_ready", sched_ready, 1'b0);
    endCycle();
    applyStimulus(1'b1, 1, 4'h3, 32'h44, 44'h9, 1'b1, 1'b0, 0, 32'h0, 1'b1);
    midCycle();
    checkOutput("t4_unblocked_ready", sched_ready, 1'b1);
    endCycle();
    drainAll();

    $display("[TB] output backpressure");
    delivered = 0;
    sendReq(0, 32'h80, 1'b0);
    sendReq(1, 32'h84, 1'b0);
    sendReq(2, 32'h88, 1'b0);
    sendRsp(0, 32'hc0, 1'b0);
    sendRsp(1, 32'hc1, 1'b0);
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b0, 0, '0, '0, '0, 1'b1, 1'b1, 2, 32'hc2, 1'b0);
      midCycle();
      checkOutput("t5_rsp_blocked", icache_rsp_ready, 1'b0);
      endCycle();
    end
    drainAll();
    checkOutput("t5_delivered", delivered, 3);

    $display("[TB] reset mid-flight");
    sendReq(0, 32'h300, 1'b1);
    sendReq(1, 32'h304, 1'b1);
    reset = 1'b1;
    modelReset();
    idleCycle(1'b1);
    reset = 1'b0;
    applyStimulus(1'b0, 0, '0, '0, '0, 1'b1, 1'b1, 0, 32'hdead, 1'b1);
    midCycle();
    checkOutput("t6_stale_accepted", icache_rsp_ready, 1'b1);
    endCycle();
    applyStimulus(1'b0, 0, '0, '0, '0, 1'b1, 1'b0, 0, 32'h0, 1'b1);
    midCycle();
    checkOutput("t6_no_output", fetch_valid, 1'b0);
    checkOutput("t6_not_busy", busy, 1'b0);
    endCycle();

    $display("[TB] random traffic");
    for (int c = 0; c < 500; c++) begin
      logic rv;
      int   rtag;
      pend.delete();
      for (int w = 0; w < NUM_WARPS; w++) if (modelPending[w]) pend.push_back(w);
      rv   = (pend.size() > 0) && ($urandom_range(0, 2) != 0);
      rtag = rv ? pend[$urandom_range(0, pend.size() - 1)] : 0;
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, NUM_WARPS - 1),
                    NUM_THREADS'($urandom), $urandom, UUID_WIDTH'({$urandom, $urandom}),
                    $urandom_range(0, 3) != 0, rv, rtag, $urandom,
                    $urandom_range(0, 3) != 0);
      runCycle();
    end
    drainAll();

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
